mvb_poll_scheduler: RTL and testbench
=====================================

# mvb_poll_scheduler

Bus-master poll scheduler for the MVB transmit path. Once per basic period it walks a register-loaded poll table, pushes each entry's 16-bit master-frame word into the encoder FIFO, and pulses the encoder's frame-start. It waits for the encoder's frame-over signal, then waits for the slave reply or a reply timeout before moving to the next entry. It sits between the host/register interface and the encoder, and it owns that encoder's `send_frame`, `M_frame`, `S_frame`, `frame_length` and FIFO write-side inputs.

## Interface
Parameters:
- `ENTRIES`, default 16: poll table depth (power of two).
- `PERIOD_CYC`, default 24000: basic period in `clk_24M` cycles (1 ms).
- `REPLY_TIMEOUT`, default 1024: reply wait in cycles (≈42.7 µs).
- `FIFO_SETTLE`, default 4: cycles from FIFO write to `send_frame`, covering the FIFO write-to-read latency.

Ports:
- `clk_24M`, in, 1: the block's only clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `enable`, in, 1: scheduler run enable.
- `tbl_we`, in, 1: poll table write strobe.
- `tbl_addr`, in, log2(ENTRIES): poll table write index.
- `tbl_wdata`, in, 18: entry contents. [17] valid, [16] expect_reply, [15:0] master-frame word (F_code[15:12], address[11:0]).
- `list_len`, in, log2(ENTRIES)+1: number of active entries, 0..ENTRIES.
- `fifo_full`, in, 1: encoder FIFO full.
- `frame_over`, in, 1: encoder finished transmitting (level or pulse).
- `decode_frame_over`, in, 1: slave frame received.
- `fifo_write_en`, out, 1: one-cycle FIFO write strobe.
- `fifo_data`, out, 16: FIFO write word.
- `send_frame`, out, 1: one-cycle frame-start pulse.
- `M_frame`, out, 1: master frame select.
- `S_frame`, out, 1: tied 0.
- `frame_length`, out, 7: constant 1 (one word).
- `busy`, out, 1: a poll cycle is in progress.
- `cur_index`, out, log2(ENTRIES): entry being served.
- `reply_ok`, out, 1: pulse when a reply is received.
- `reply_timeout`, out, 1: pulse when a reply times out.
- `timeout_cnt`, out, 8: saturating count of timeouts.
- `cycle_done`, out, 1: pulse at the end of a poll cycle.
- `overrun`, out, 1: sticky; set when a period tick arrives while `busy`.

## Operation
- **Period timer.** Counts 0..PERIOD_CYC-1 while `enable`=1 and holds 0 while `enable`=0. The tick is the cycle the count equals PERIOD_CYC-1.
- **Poll table.** Written at any time; reads happen in LOAD, so a write takes effect on the next LOAD of that index.
- **FSM states.**
  - IDLE: on tick, go to LOAD with index 0 and `busy`=1. If `list_len`=0, pulse `cycle_done` and stay in IDLE.
  - LOAD: latch the entry. valid=0 → NEXT; valid=1 → PUSH.
  - PUSH: while `fifo_full`=1, wait. Otherwise assert `fifo_write_en` for one cycle with `fifo_data`=word, then go to SETTLE.
  - SETTLE: count FIFO_SETTLE cycles, then go to SEND.
  - SEND: `send_frame`=1 for one cycle; `M_frame`=1 from SEND until leaving WAIT_TX.
  - WAIT_TX: wait for `frame_over`=1. expect_reply=1 → WAIT_REPLY with the counter cleared; expect_reply=0 → NEXT.
  - WAIT_REPLY: counter increments each cycle.
    - `decode_frame_over`=1 → pulse `reply_ok`, go to NEXT.
    - Counter reaches REPLY_TIMEOUT-1 → pulse `reply_timeout`, increment `timeout_cnt` (saturates at 255), go to NEXT.
  - NEXT: if index = `list_len`-1, or `enable`=0 → pulse `cycle_done`, clear `busy`, go to IDLE. Otherwise increment index and go to LOAD.
- **Simultaneous events.**
  - Reply and timeout in the same cycle: reply wins, no timeout counted.
  - Tick while `busy`: sets `overrun` and is otherwise ignored (no restart).
  - `enable` drops mid-cycle: the current entry completes, then the FSM goes to IDLE through NEXT.
- **Reset.** All outputs 0 except `frame_length`=1. Valid bits are cleared, the period count is 0, the FSM is in IDLE and `overrun` is cleared. Reset mid-transfer aborts immediately; the encoder is not otherwise signalled.

## Timing
- The first LOAD is the cycle after the tick. Skipping an invalid entry costs 2 cycles (LOAD, NEXT).
- Valid entry, FIFO not full: `fifo_write_en` occurs 2 cycles after the tick for index 0, and `send_frame` occurs FIFO_SETTLE+1 cycles after `fifo_write_en`.
- `reply_timeout` pulses REPLY_TIMEOUT cycles after the cycle `frame_over` is sampled.
- Every pulse output is exactly 1 cycle wide. `cur_index` is stable from LOAD through NEXT.

## Test plan
Bench parameters: PERIOD_CYC=200, REPLY_TIMEOUT=16, FIFO_SETTLE=4.

1. **Normal poll.** Entries 0–2 valid with expect_reply=1, `list_len`=3, reply 5 cycles after each `frame_over` → three writes with words 0x1001/0x1002/0x1003, three `send_frame`, three `reply_ok`, one `cycle_done`, `timeout_cnt`=0.
2. **Timeout.** Entry 0 never answered → `reply_timeout` exactly 16 cycles after `frame_over`; `timeout_cnt`=1; next entry served. Reply and timeout in the same cycle → `reply_ok` only.
3. **Invalid entries and empty list.** Entry 1 invalid, `list_len`=3 → FIFO words only for indices 0 and 2. `list_len`=0 → `cycle_done` on the tick cycle+1, no writes.
4. **Back-pressure.** `fifo_full`=1 for 10 cycles during PUSH → no `fifo_write_en` until `fifo_full` falls; the word is written once.
5. **Overrun and enable.**
   - Slave replies delayed so the cycle exceeds 200 cycles → `overrun`=1 and no restart.
   - `enable` dropped during WAIT_TX of entry 0 of 3 → entry 0 completes, `cycle_done`, IDLE.
6. **Mid-operation reset.** `rst` asserted during WAIT_REPLY → next cycle all outputs at reset values, `busy`=0. After release, the first `send_frame` requires a full period plus re-written entries.

Source files
------------

// File: rtl/mvb_poll_scheduler.sv
// mvb_poll_scheduler
// Once per basic period, walks the poll table and issues one master frame per
// valid entry to the MVB encoder. After each frame it waits for the slave
// reply, or for a reply timeout, before it moves on to the next entry.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a period tick
// LOAD       | latch table entry at cur_index; write it now if FIFO has room
// PUSH       | entry latched, FIFO full; write as soon as it drains
// SETTLE     | let the FIFO write reach the encoder read side
// SEND       | issue send_frame (visible next cycle)
// WAIT_TX    | encoder transmitting, waiting for frame_over
// WAIT_REPLY | waiting for slave frame or reply timeout
// NEXT       | advance index or finish the poll cycle
//
// Every output is a register, so a pulse shows up the cycle after the state
// that decides it. The counter compare values below allow for that one-cycle
// delay.
module mvb_poll_scheduler #(
  parameter int ENTRIES       = 16,
  parameter int PERIOD_CYC    = 24000,
  parameter int REPLY_TIMEOUT = 1024,
  parameter int FIFO_SETTLE   = 4
) (
  input  logic                        clk_24M,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        tbl_we,
  input  logic [$clog2(ENTRIES)-1:0]  tbl_addr,
  input  logic [17:0]                 tbl_wdata,
  input  logic [$clog2(ENTRIES):0]    list_len,
  input  logic                        fifo_full,
  input  logic                        frame_over,
  input  logic                        decode_frame_over,
  output logic                        fifo_write_en,
  output logic [15:0]                 fifo_data,
  output logic                        send_frame,
  output logic                        M_frame,
  output logic                        S_frame,
  output logic [6:0]                  frame_length,
  output logic                        busy,
  output logic [$clog2(ENTRIES)-1:0]  cur_index,
  output logic                        reply_ok,
  output logic                        reply_timeout,
  output logic [7:0]                  timeout_cnt,
  output logic                        cycle_done,
  output logic                        overrun
);

  localparam int IW = $clog2(ENTRIES);
  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int RW = (REPLY_TIMEOUT > 2) ? $clog2(REPLY_TIMEOUT) : 1;
  localparam int SW = $clog2(FIFO_SETTLE + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  // Compare one below the nominal terminal count, so the registered
  // reply_timeout pulse lands exactly REPLY_TIMEOUT cycles after frame_over.
  localparam logic [RW-1:0] REPLY_LAST  = RW'(REPLY_TIMEOUT - 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(FIFO_SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PUSH,
    S_SETTLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_REPLY,
    S_NEXT
  } state_t;

  state_t              state;
  logic [PW-1:0]       period_cnt;
  logic                tick;
  logic [RW-1:0]       reply_cnt;
  logic [SW-1:0]       settle_cnt;
  logic [15:0]         cur_word;
  logic                cur_reply;
  logic [IW:0]         next_index;
  logic                last_entry;

  logic [15:0]         tbl_word [ENTRIES];
  logic [ENTRIES-1:0]  tbl_reply;
  logic [ENTRIES-1:0]  tbl_valid;

  assign S_frame      = 1'b0;
  assign frame_length = 7'd1;

  assign tick       = (period_cnt == PERIOD_LAST);
  assign next_index = {1'b0, cur_index} + (IW+1)'(1);
  // ">=" rather than "==" so that shrinking list_len mid-cycle still ends the walk
  assign last_entry = (next_index >= list_len);

  // Basic period timer: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk_24M) begin
    if (rst || !enable) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // Valid bits are reset so a reset leaves an empty table.
  always_ff @(posedge clk_24M) begin
    if (rst) begin
      tbl_valid <= '0;
    end else if (tbl_we) begin
      tbl_valid[tbl_addr] <= tbl_wdata[17];
    end
  end

  // Entry payload storage; only meaningful once its valid bit is set.
  always_ff @(posedge clk_24M) begin
    if (tbl_we) begin
      tbl_word[tbl_addr]  <= tbl_wdata[15:0];
      tbl_reply[tbl_addr] <= tbl_wdata[16];
    end
  end

  // Poll sequencer with registered encoder handshake and status outputs.
  always_ff @(posedge clk_24M) begin
    if (rst) begin
      state         <= S_IDLE;
      fifo_write_en <= 1'b0;
      fifo_data     <= '0;
      send_frame    <= 1'b0;
      M_frame       <= 1'b0;
      busy          <= 1'b0;
      cur_index     <= '0;
      reply_ok      <= 1'b0;
      reply_timeout <= 1'b0;
      timeout_cnt   <= '0;
      cycle_done    <= 1'b0;
      overrun       <= 1'b0;
      reply_cnt     <= '0;
      settle_cnt    <= '0;
      cur_word      <= '0;
      cur_reply     <= 1'b0;
    end else begin
      fifo_write_en <= 1'b0;
      send_frame    <= 1'b0;
      reply_ok      <= 1'b0;
      reply_timeout <= 1'b0;
      cycle_done    <= 1'b0;

      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (tick) begin
            cur_index <= '0;
            if (list_len == '0) begin
              cycle_done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          cur_word  <= tbl_word[cur_index];
          cur_reply <= tbl_reply[cur_index];
          if (!tbl_valid[cur_index]) begin
            state <= S_NEXT;
          end else if (fifo_full) begin
            state <= S_PUSH;
          end else begin
            fifo_write_en <= 1'b1;
            fifo_data     <= tbl_word[cur_index];
            settle_cnt    <= '0;
            state         <= S_SETTLE;
          end
        end

        S_PUSH: begin
          if (!fifo_full) begin
            fifo_write_en <= 1'b1;
            fifo_data     <= cur_word;
            settle_cnt    <= '0;
            state         <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_SEND;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        S_SEND: begin
          send_frame <= 1'b1;
          M_frame    <= 1'b1;
          state      <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          // A frame_over level left over from the previous frame can still be
          // high while the encoder sees send_frame, so ignore that one cycle.
          if (frame_over && !send_frame) begin
            M_frame <= 1'b0;
            if (cur_reply) begin
              reply_cnt <= '0;
              state     <= S_WAIT_REPLY;
            end else begin
              state <= S_NEXT;
            end
          end
        end

        S_WAIT_REPLY: begin
          if (decode_frame_over) begin
            reply_ok <= 1'b1;
            state    <= S_NEXT;
          end else if (reply_cnt == REPLY_LAST) begin
            reply_timeout <= 1'b1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state <= S_NEXT;
          end else begin
            reply_cnt <= reply_cnt + RW'(1);
          end
        end

        S_NEXT: begin
          if (last_entry || !enable) begin
            cycle_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cur_index <= cur_index + IW'(1);
            state     <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvb_poll_scheduler.sv
// Testbench for mvb_poll_scheduler: scoreboard of expected FIFO words,
// a simple encoder/slave responder, and one task per scenario.
module tb_mvb_poll_scheduler;

  localparam int ENTRIES = 16;
  localparam int P       = 200;
  localparam int RT      = 16;
  localparam int FS      = 4;

  logic        clk_24M = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [17:0] tbl_wdata = '0;
  logic [4:0]  list_len = '0;
  logic        fifo_full = 1'b0;
  logic        frame_over = 1'b0;
  logic        decode_frame_over = 1'b0;

  logic        fifo_write_en;
  logic [15:0] fifo_data;
  logic        send_frame;
  logic        M_frame;
  logic        S_frame;
  logic [6:0]  frame_length;
  logic        busy;
  logic [3:0]  cur_index;
  logic        reply_ok;
  logic        reply_timeout;
  logic [7:0]  timeout_cnt;
  logic        cycle_done;
  logic        overrun;

  mvb_poll_scheduler #(
    .ENTRIES(ENTRIES), .PERIOD_CYC(P), .REPLY_TIMEOUT(RT), .FIFO_SETTLE(FS)
  ) dut (
    .clk_24M(clk_24M), .rst(rst), .enable(enable),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .list_len(list_len), .fifo_full(fifo_full), .frame_over(frame_over),
    .decode_frame_over(decode_frame_over),
    .fifo_write_en(fifo_write_en), .fifo_data(fifo_data),
    .send_frame(send_frame), .M_frame(M_frame), .S_frame(S_frame),
    .frame_length(frame_length), .busy(busy), .cur_index(cur_index),
    .reply_ok(reply_ok), .reply_timeout(reply_timeout),
    .timeout_cnt(timeout_cnt), .cycle_done(cycle_done), .overrun(overrun)
  );

  always #5 clk_24M = ~clk_24M;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] sb[$];
  logic [15:0] exp_w;
  logic [4:0]  cur_p;
  logic [4:0]  prev_p = '0;

  int n_write = 0, n_send = 0, n_ok = 0, n_to = 0, n_done = 0, n_fo = 0;
  int t_first_write = -1, t_first_send = -1, t_done = -1;
  int fo_times[$];
  int to_times[$];

  int tx_delay   = 3;
  int default_rd = 5;
  int reply_plan[$];
  int tx_cd  = -1;
  int rp_cd  = -1;
  int cur_rd = -1;

  // Monitor (mid-cycle sampling) plus encoder/slave responder.
  initial begin
    forever begin
      @(negedge clk_24M);
      cyc++;
      frame_over = 1'b0;
      decode_frame_over = 1'b0;
      if (rst) begin
        n_write = 0; n_send = 0; n_ok = 0; n_to = 0; n_done = 0; n_fo = 0;
        t_first_write = -1; t_first_send = -1; t_done = -1;
        fo_times.delete(); to_times.delete();
        tx_cd = -1; rp_cd = -1; prev_p = '0;
      end else begin
        cur_p = {fifo_write_en, send_frame, reply_ok, reply_timeout, cycle_done};
        for (int i = 0; i < 5; i++) begin
          if (cur_p[i]) begin
            n_checks++;
            if (prev_p[i])
              $display("FAIL pulse_width[%0d]: high 2+ cycles at cycle %0d, required 1 cycle", i, cyc);
            else
              n_pass++;
          end
        end
        prev_p = cur_p;

        if (fifo_write_en) begin
          n_write++;
          if (t_first_write < 0) t_first_write = cyc;
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL fifo_word: unexpected write 0x%h at cycle %0d, required no write", fifo_data, cyc);
          end else begin
            exp_w = sb.pop_front();
            if (fifo_data !== exp_w)
              $display("FAIL fifo_word: got 0x%h, required 0x%h", fifo_data, exp_w);
            else
              n_pass++;
          end
        end
        if (send_frame) begin
          n_send++;
          if (t_first_send < 0) t_first_send = cyc;
        end
        if (reply_ok) n_ok++;
        if (reply_timeout) begin
          n_to++;
          to_times.push_back(cyc);
        end
        if (cycle_done) begin
          n_done++;
          t_done = cyc;
        end

        if (tx_cd > 0) begin
          tx_cd--;
          if (tx_cd == 0) begin
            frame_over = 1'b1;
            n_fo++;
            fo_times.push_back(cyc);
            tx_cd = -1;
            if (cur_rd > 0) rp_cd = cur_rd;
          end
        end else if (rp_cd > 0) begin
          rp_cd--;
          if (rp_cd == 0) begin
            decode_frame_over = 1'b1;
            rp_cd = -1;
          end
        end
        if (send_frame) begin
          tx_cd  = tx_delay;
          cur_rd = (reply_plan.size() > 0) ? reply_plan.pop_front() : default_rd;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk_24M);
      #1;
    end
  endtask

  task automatic write_entry(int idx, logic v, logic er, logic [15:0] w);
    tbl_we    = 1'b1;
    tbl_addr  = idx[3:0];
    tbl_wdata = {v, er, w};
    step(1);
    tbl_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tbl_we = 1'b0;
    fifo_full = 1'b0;
    list_len = '0;
    reply_plan.delete();
    sb.delete();
    tx_delay = 3;
    default_rd = 5;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    logic [8:0] rv;
    rst = 1'b1;
    step(2);
    rv = {fifo_write_en, send_frame, M_frame, S_frame, busy, reply_ok, reply_timeout, cycle_done, overrun};
    n_checks++;
    if (rv !== 9'b0) $display("FAIL reset_flags: got %b, required 000000000", rv); else n_pass++;
    n_checks++;
    if (fifo_data !== 16'h0) $display("FAIL reset_fifo_data: got 0x%h, required 0x0000", fifo_data); else n_pass++;
    n_checks++;
    if (timeout_cnt !== 8'd0) $display("FAIL reset_timeout_cnt: got %0d, required 0", timeout_cnt); else n_pass++;
    n_checks++;
    if (cur_index !== 4'd0) $display("FAIL reset_cur_index: got %0d, required 0", cur_index); else n_pass++;
    n_checks++;
    if (frame_length !== 7'd1) $display("FAIL reset_frame_length: got %0d, required 1", frame_length); else n_pass++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_normal_poll();
    int t_en;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write_entry(i, 1'b1, 1'b1, 16'h1001 + 16'(i));
      sb.push_back(16'h1001 + 16'(i));
    end
    list_len = 5'd3;
    enable = 1'b1;
    t_en = cyc + 1;
    for (int i = 0; i < 400 && n_done < 1; i++) step(1);
    n_checks++;
    if (n_done != 1) $display("FAIL normal_done: cycle_done count %0d, required 1", n_done); else n_pass++;
    n_checks++;
    if (t_first_write - t_en != P + 1) $display("FAIL normal_write_latency: write at enable+%0d, required enable+%0d", t_first_write - t_en, P + 1); else n_pass++;
    n_checks++;
    if (t_first_send - t_first_write != FS + 1) $display("FAIL normal_send_latency: got %0d, required %0d", t_first_send - t_first_write, FS + 1); else n_pass++;
    n_checks++;
    if (n_write != 3 || n_send != 3 || n_ok != 3) $display("FAIL normal_counts: writes %0d sends %0d oks %0d, required 3 3 3", n_write, n_send, n_ok); else n_pass++;
    n_checks++;
    if (timeout_cnt !== 8'd0) $display("FAIL normal_timeout_cnt: got %0d, required 0", timeout_cnt); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || cur_index !== 4'd2 || M_frame !== 1'b0) $display("FAIL normal_final: busy %b idx %0d M_frame %b, required 0 2 0", busy, cur_index, M_frame); else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL normal_sb_left: %0d words unwritten, required 0", sb.size()); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    write_entry(0, 1'b1, 1'b1, 16'h2A05);
    sb.push_back(16'h2A05);
    write_entry(1, 1'b1, 1'b1, 16'h2B06);
    sb.push_back(16'h2B06);
    reply_plan.push_back(-1);
    reply_plan.push_back(RT - 1);
    list_len = 5'd2;
    enable = 1'b1;
    for (int i = 0; i < 400 && n_done < 1; i++) step(1);
    n_checks++;
    if (n_done != 1) $display("FAIL timeout_done: cycle_done count %0d, required 1", n_done); else n_pass++;
    n_checks++;
    if (to_times.size() == 0 || fo_times.size() == 0)
      $display("FAIL timeout_latency: timeouts %0d frame_overs %0d, required at least 1 each", to_times.size(), fo_times.size());
    else if (to_times[0] - fo_times[0] != RT)
      $display("FAIL timeout_latency: got %0d cycles, required %0d", to_times[0] - fo_times[0], RT);
    else n_pass++;
    n_checks++;
    if (n_to != 1 || timeout_cnt !== 8'd1) $display("FAIL timeout_count: pulses %0d cnt %0d, required 1 1", n_to, timeout_cnt); else n_pass++;
    n_checks++;
    if (n_ok != 1) $display("FAIL timeout_coincident_reply: reply_ok %0d, required 1", n_ok); else n_pass++;
    n_checks++;
    if (n_write != 2 || sb.size() != 0) $display("FAIL timeout_next_entry: writes %0d left %0d, required 2 0", n_write, sb.size()); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_invalid_and_empty();
    int t_en;
    int snap_w;
    int snap_d;
    do_reset();
    write_entry(0, 1'b1, 1'b0, 16'h3100);
    sb.push_back(16'h3100);
    write_entry(1, 1'b0, 1'b0, 16'h3F01);
    write_entry(2, 1'b1, 1'b0, 16'h3102);
    sb.push_back(16'h3102);
    list_len = 5'd3;
    enable = 1'b1;
    for (int i = 0; i < 400 && n_done < 1; i++) step(1);
    n_checks++;
    if (n_write != 2 || n_send != 2 || sb.size() != 0) $display("FAIL invalid_skip: writes %0d sends %0d left %0d, required 2 2 0", n_write, n_send, sb.size()); else n_pass++;
    n_checks++;
    if (n_ok != 0 || n_to != 0) $display("FAIL invalid_no_reply: ok %0d to %0d, required 0 0", n_ok, n_to); else n_pass++;

    enable = 1'b0;
    list_len = 5'd0;
    step(2);
    snap_w = n_write;
    snap_d = n_done;
    enable = 1'b1;
    t_en = cyc + 1;
    for (int i = 0; i < 300 && n_done < snap_d + 1; i++) step(1);
    n_checks++;
    if (n_done != snap_d + 1) $display("FAIL empty_done: cycle_done count %0d, required %0d", n_done, snap_d + 1); else n_pass++;
    n_checks++;
    if (t_done - t_en != P) $display("FAIL empty_done_time: at enable+%0d, required enable+%0d", t_done - t_en, P); else n_pass++;
    n_checks++;
    if (n_write != snap_w || busy !== 1'b0) $display("FAIL empty_no_write: writes %0d busy %b, required %0d 0", n_write, busy, snap_w); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_back_pressure();
    int t_drop;
    do_reset();
    write_entry(0, 1'b1, 1'b0, 16'h4444);
    sb.push_back(16'h4444);
    list_len = 5'd1;
    fifo_full = 1'b1;
    enable = 1'b1;
    step(P + 11);
    n_checks++;
    if (n_write != 0) $display("FAIL bp_held: writes %0d while full, required 0", n_write); else n_pass++;
    fifo_full = 1'b0;
    t_drop = cyc + 1;
    for (int i = 0; i < 100 && n_done < 1; i++) step(1);
    n_checks++;
    if (t_first_write != t_drop + 1) $display("FAIL bp_write_time: cycle %0d, required %0d", t_first_write, t_drop + 1); else n_pass++;
    n_checks++;
    if (n_write != 1 || n_done != 1 || sb.size() != 0) $display("FAIL bp_once: writes %0d done %0d left %0d, required 1 1 0", n_write, n_done, sb.size()); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write_entry(i, 1'b1, 1'b1, 16'h7010 + 16'(i));
      sb.push_back(16'h7010 + 16'(i));
    end
    tx_delay = 60;
    list_len = 5'd4;
    enable = 1'b1;
    for (int i = 0; i < 700 && n_done < 1; i++) step(1);
    enable = 1'b0;
    n_checks++;
    if (n_done != 1) $display("FAIL overrun_done: cycle_done count %0d, required 1", n_done); else n_pass++;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b, required 1", overrun); else n_pass++;
    n_checks++;
    if (n_write != 4 || sb.size() != 0) $display("FAIL overrun_no_restart: writes %0d left %0d, required 4 0", n_write, sb.size()); else n_pass++;
    step(50);
    n_checks++;
    if (overrun !== 1'b1 || n_write != 4) $display("FAIL overrun_sticky: flag %b writes %0d, required 1 4", overrun, n_write); else n_pass++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    for (int i = 0; i < 3; i++) write_entry(i, 1'b1, 1'b0, 16'h5000 + 16'(i));
    sb.push_back(16'h5000);
    tx_delay = 10;
    list_len = 5'd3;
    enable = 1'b1;
    for (int i = 0; i < 300 && n_send < 1; i++) step(1);
    enable = 1'b0;
    for (int i = 0; i < 100 && n_done < 1; i++) step(1);
    n_checks++;
    if (n_done != 1 || busy !== 1'b0) $display("FAIL endrop_done: done %0d busy %b, required 1 0", n_done, busy); else n_pass++;
    n_checks++;
    if (n_write != 1 || n_send != 1) $display("FAIL endrop_entry0_only: writes %0d sends %0d, required 1 1", n_write, n_send); else n_pass++;
    step(P + 20);
    n_checks++;
    if (n_write != 1 || n_done != 1) $display("FAIL endrop_idle: writes %0d done %0d, required 1 1", n_write, n_done); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int t_rst;
    logic [8:0] rv;
    do_reset();
    write_entry(0, 1'b1, 1'b1, 16'h6001);
    sb.push_back(16'h6001);
    default_rd = -1;
    list_len = 5'd1;
    enable = 1'b1;
    for (int i = 0; i < 300 && n_fo < 1; i++) step(1);
    step(3);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b, required 1", busy); else n_pass++;
    rst = 1'b1;
    t_rst = cyc + 1;
    step(1);
    rv = {fifo_write_en, send_frame, M_frame, S_frame, busy, reply_ok, reply_timeout, cycle_done, overrun};
    n_checks++;
    if (rv !== 9'b0 || timeout_cnt !== 8'd0 || frame_length !== 7'd1) $display("FAIL midrst_outputs: flags %b tcnt %0d flen %0d, required 0 0 1", rv, timeout_cnt, frame_length); else n_pass++;
    rst = 1'b0;
    sb.delete();
    default_rd = 5;
    for (int i = 0; i < 300 && n_done < 1; i++) step(1);
    n_checks++;
    if (n_done != 1 || n_write != 0 || n_send != 0) $display("FAIL midrst_cleared_table: done %0d writes %0d sends %0d, required 1 0 0", n_done, n_write, n_send); else n_pass++;
    write_entry(0, 1'b1, 1'b1, 16'h6001);
    sb.push_back(16'h6001);
    for (int i = 0; i < 300 && n_send < 1; i++) step(1);
    n_checks++;
    if (t_first_send != t_rst + 2 * P + 7) $display("FAIL midrst_send_time: cycle %0d, required %0d", t_first_send, t_rst + 2 * P + 7); else n_pass++;
    for (int i = 0; i < 100 && n_done < 2; i++) step(1);
    n_checks++;
    if (n_done != 2 || n_ok != 1 || sb.size() != 0) $display("FAIL midrst_recovered: done %0d ok %0d left %0d, required 2 1 0", n_done, n_ok, sb.size()); else n_pass++;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_poll();
    test_timeout();
    test_invalid_and_empty();
    test_back_pressure();
    test_overrun();
    test_enable_drop();
    test_mid_reset();
    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
